// File: rtl/bluemax_jtag_scan_master.sv
// rtl/bluemax_jtag_scan_master.sv - JTAG scan initiator: turns IR/DR/reset commands into TCK/TMS/TDI slots
// Every sequence starts and ends in Run-Test/Idle; tdo bits are returned LSB-first.
module bluemax_jtag_scan_master #(
    parameter int MAX_LEN = 64,
    parameter int HALF    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [6:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    localparam int         IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0] PH_HI   = 9'(HALF);
    localparam logic [8:0] PH_LAST = 9'(2 * HALF - 1);
    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

    typedef enum logic [2:0] {
        S_RESET_SEQ,
        S_IDLE,
        S_HDR,
        S_SHIFT,
        S_TRAILER,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [8:0]         ph_q, ph_d;
    logic [6:0]         slot_q, slot_d;
    logic [6:0]         len_q, len_d;
    logic               op_ir_q, op_ir_d;
    logic               rst_cmd_q, rst_cmd_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;

    logic               slot_end;
    logic [6:0]         slot_inc;
    logic [6:0]         len_clamp;
    logic               running;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        slot_d     = slot_q;
        len_d      = len_q;
        op_ir_d    = op_ir_q;
        rst_cmd_d  = rst_cmd_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;

        slot_end  = (ph_q == PH_LAST);
        slot_inc  = slot_q + 7'd1;
        len_clamp = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
        running   = (state_q == S_RESET_SEQ) || (state_q == S_HDR) ||
                    (state_q == S_SHIFT) || (state_q == S_TRAILER);

        // Slot timer: low phase for HALF cycles, high phase for HALF cycles.
        if (running) begin
            if (slot_end) begin
                ph_d  = 9'd0;
                tck_d = 1'b0;
            end else begin
                ph_d  = ph_q + 9'd1;
                tck_d = ((ph_q + 9'd1) >= PH_HI);
            end
        end

        // tdo is taken on the cycle tck first reads high in a shift slot.
        if (state_q == S_SHIFT && ph_q == PH_HI) begin
            rsp_data_d[slot_q[IW-1:0]] = tdo;
        end

        case (state_q)
            S_RESET_SEQ: begin
                if (slot_end) begin
                    if (slot_q == 7'd5) begin
                        state_d = rst_cmd_q ? S_RESP : S_IDLE;
                        slot_d  = 7'd0;
                        tms_d   = 1'b0;
                    end else begin
                        slot_d = slot_inc;
                        tms_d  = (slot_q < 7'd4);
                    end
                end
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    op_ir_d    = (cmd_op == 2'd1);
                    data_d     = cmd_data;
                    len_d      = len_clamp;
                    rsp_data_d = '0;
                    slot_d     = 7'd0;
                    ph_d       = 9'd0;
                    tck_d      = 1'b0;
                    tdi_d      = 1'b0;
                    if (cmd_op[1]) begin
                        rst_cmd_d = 1'b1;
                        state_d   = S_RESET_SEQ;
                        tms_d     = 1'b1;
                    end else if (len_clamp == 7'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_HDR;
                        tms_d   = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (slot_end) begin
                    if (slot_q == (op_ir_q ? 7'd3 : 7'd2)) begin
                        state_d = S_SHIFT;
                        slot_d  = 7'd0;
                        tms_d   = (len_q == 7'd1);
                        tdi_d   = data_q[0];
                    end else begin
                        slot_d = slot_inc;
                        tms_d  = op_ir_q && (slot_q == 7'd0);
                    end
                end
            end
            S_SHIFT: begin
                if (slot_end) begin
                    if (slot_inc == len_q) begin
                        state_d = S_TRAILER;
                        slot_d  = 7'd0;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end else begin
                        slot_d = slot_inc;
                        tms_d  = ((slot_inc + 7'd1) == len_q);
                        tdi_d  = data_q[slot_inc[IW-1:0]];
                    end
                end
            end
            S_TRAILER: begin
                if (slot_end) begin
                    tms_d = 1'b0;
                    if (slot_q == 7'd0) begin
                        slot_d = 7'd1;
                    end else begin
                        state_d = S_RESP;
                        slot_d  = 7'd0;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d   = S_IDLE;
                    rst_cmd_d = 1'b0;
                end
            end
            default: begin
                state_d = S_RESET_SEQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RESET_SEQ;
            ph_q       <= 9'd0;
            slot_q     <= 7'd0;
            len_q      <= 7'd0;
            op_ir_q    <= 1'b0;
            rst_cmd_q  <= 1'b0;
            data_q     <= '0;
            rsp_data_q <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            slot_q     <= slot_d;
            len_q      <= len_d;
            op_ir_q    <= op_ir_d;
            rst_cmd_q  <= rst_cmd_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

endmodule
